// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The counter width helper keeps the starvation counter just wide enough for its limit.
package definitions;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;

    function automatic int ctr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating counter of contested cycles the host has lost; cleared whenever the host is served.
module starve_ctr
    import definitions::*;
#(
    parameter int MAX = STARVE_MAX_DEFAULT,
    parameter int CW  = ctr_width(MAX)
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over increment so a granted host never carries stale starvation.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core load/store path and the host port.
// Core has priority, bounded by a starvation counter; the host may lock the memory for bursts.
module dmem_arbiter
    import definitions::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    logic       starve_max;
    logic       core_win, host_win;

    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          core_rvalid_q, core_rvalid_d;
    logic          host_rvalid_q, host_rvalid_d;

    starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .CLK     (CLK),
        .reset_n (reset_n),
        .inc     (host_req && !host_win),
        .clr     (host_win),
        .at_max  (starve_max)
    );

    // Grants are gated by reset so every output reads zero while reset is held.
    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        if (reset_n) begin
            if (state_q == ARB_LOCKED) begin
                host_win = host_req;
            end else if (core_req && host_req) begin
                if (starve_max) begin
                    host_win = 1'b1;
                end else begin
                    core_win = 1'b1;
                end
            end else begin
                core_win = core_req;
                host_win = host_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (host_win && host_lock) state_d = ARB_LOCKED;
            ARB_LOCKED: if (!host_lock)            state_d = ARB_IDLE;
            default:                               state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (core_win) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end else if (host_win) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end
    end

    // Read data lands in the winner's register; the other port keeps its last value.
    always_comb begin
        core_rdata_d  = core_rdata_q;
        host_rdata_d  = host_rdata_q;
        core_rvalid_d = core_win && !core_we;
        host_rvalid_d = host_win && !host_we;
        if (core_rvalid_d) core_rdata_d = mem_rdata;
        if (host_rvalid_d) host_rdata_d = mem_rdata;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign core_gnt    = core_win;
    assign host_gnt    = host_win;
    assign core_stall  = reset_n && core_req && !core_win;
    assign core_rdata  = core_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign core_rvalid = core_rvalid_q;
    assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, reference model and read scoreboard.
module tb_dmem_arbiter;

    localparam int SMAX = 4;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b1;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       core_gnt, core_stall, core_rvalid;
    logic [7:0] core_rdata;
    logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    logic [7:0] tb_mem  [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    typedef struct packed {
        logic       is_host;
        logic [7:0] data;
    } rd_t;

    rd_t        sb_q[$];
    int         total = 0;
    int         bad = 0;
    logic       m_locked = 1'b0;
    int         m_starve = 0;
    logic [7:0] last_c = '0, last_h = '0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SMAX)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    // Stand-in for data_mem: combinational read, write at the clock edge.
    always @(posedge CLK) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string when);
        checkOutput({when, "_core_gnt"},    core_gnt,    0);
        checkOutput({when, "_core_stall"},  core_stall,  0);
        checkOutput({when, "_core_rvalid"}, core_rvalid, 0);
        checkOutput({when, "_core_rdata"},  core_rdata,  0);
        checkOutput({when, "_host_gnt"},    host_gnt,    0);
        checkOutput({when, "_host_rvalid"}, host_rvalid, 0);
        checkOutput({when, "_host_rdata"},  host_rdata,  0);
        checkOutput({when, "_mem_addr"},    mem_addr,    0);
        checkOutput({when, "_mem_wdata"},   mem_wdata,   0);
        checkOutput({when, "_mem_we"},      mem_we,      0);
    endtask

    task automatic setInputs(input logic creq, cwe, input logic [7:0] caddr, cwdata,
                             input logic hreq, hwe, hlock, input logic [7:0] haddr, hwdata);
        core_req = creq;  core_we = cwe;  core_addr = caddr;  core_wdata = cwdata;
        host_req = hreq;  host_we = hwe;  host_lock = hlock;
        host_addr = haddr; host_wdata = hwdata;
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_starve = 0;
        sb_q.delete();
        last_c = '0;
        last_h = '0;
    endtask

    // One full cycle: drive at posedge+1, check grants mid-cycle, check read returns after the edge.
    task automatic applyStimulus(input logic creq, cwe, input logic [7:0] caddr, cwdata,
                                 input logic hreq, hwe, hlock, input logic [7:0] haddr, hwdata);
        logic ec, eh;
        logic [7:0] ea, ed;
        rd_t e;
        setInputs(creq, cwe, caddr, cwdata, hreq, hwe, hlock, haddr, hwdata);
        ec = 1'b0;
        eh = 1'b0;
        if (m_locked) eh = hreq;
        else if (creq && hreq) begin
            if (m_starve == SMAX) eh = 1'b1;
            else ec = 1'b1;
        end else begin
            ec = creq;
            eh = hreq;
        end
        ea = ec ? caddr : (eh ? haddr : 8'h00);
        ed = ec ? cwdata : (eh ? hwdata : 8'h00);
        #3;
        checkOutput("core_gnt",   core_gnt,   ec);
        checkOutput("host_gnt",   host_gnt,   eh);
        checkOutput("core_stall", core_stall, creq && !ec);
        checkOutput("mem_addr",   mem_addr,   ea);
        checkOutput("mem_wdata",  mem_wdata,  ed);
        checkOutput("mem_we",     mem_we,     (ec && cwe) || (eh && hwe));
        if (ec && !cwe) sb_q.push_back('{is_host: 1'b0, data: ref_mem[caddr]});
        if (eh && !hwe) sb_q.push_back('{is_host: 1'b1, data: ref_mem[haddr]});
        if (ec && cwe) ref_mem[caddr] = cwdata;
        if (eh && hwe) ref_mem[haddr] = hwdata;
        if (eh) m_starve = 0;
        else if (hreq && m_starve < SMAX) m_starve++;
        if (!m_locked && eh && hlock) m_locked = 1'b1;
        else if (m_locked && !hlock) m_locked = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("core_rvalid", core_rvalid, ec && !cwe);
        checkOutput("host_rvalid", host_rvalid, eh && !hwe);
        if (core_rvalid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("core_rd_owner", e.is_host, 0);
            last_c = e.data;
        end
        if (host_rvalid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("host_rd_owner", e.is_host, 1);
            last_h = e.data;
        end
        checkOutput("core_rdata", core_rdata, last_c);
        checkOutput("host_rdata", host_rdata, last_h);
    endtask

    initial begin
        logic [7:0] a, d;

        // Reset held with random inputs: every output must stay zero.
        #1 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setInputs(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            #7;
            checkAllZero("rst");
        end
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK) reset_n = 1'b1;
        @(posedge CLK) #1;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Preload via the host, then a simple core read.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            a = 8'h30 + 8'(i);
            d = 8'($urandom);
            applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 0, a, d);
        end
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Continuous contention: core wins four, host forced on the fifth.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 8'h30 + 8'(i % 8), 8'h00, 1, 0, 0, 8'h37 - 8'(i % 8), 8'h00);
        end

        // Same-cycle host write and core read of 0x20.
        applyStimulus(1, 0, 8'h20, 8'h00, 1, 1, 0, 8'h20, 8'h5A);
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'h5A);
        applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Build up starvation; lock request while losing is ignored.
        applyStimulus(1, 0, 8'h31, 8'h00, 1, 0, 0, 8'h32, 8'h00);
        applyStimulus(1, 0, 8'h31, 8'h00, 1, 0, 1, 8'h32, 8'h00);
        applyStimulus(1, 1, 8'h60, 8'h11, 1, 0, 0, 8'h32, 8'h00);
        applyStimulus(1, 0, 8'h60, 8'h00, 1, 0, 0, 8'h32, 8'h00);

        // Locked burst with the core requesting throughout.
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h33, 8'h00);
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h30, 8'h00);
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 1, 1, 8'h50, 8'hC3);
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h50, 8'h00);
        applyStimulus(1, 0, 8'h50, 8'h00, 1, 0, 0, 8'h34, 8'h00);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Reset while locked releases the lock.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h40, 8'h77);
        setInputs(1, 0, 8'h40, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        #3;
        checkOutput("locked_core_gnt", core_gnt, 0);
        checkOutput("locked_core_stall", core_stall, 1);
        reset_n = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkAllZero("rst_lock");
        @(negedge CLK) reset_n = 1'b1;
        modelReset();
        @(posedge CLK) #1;
        applyStimulus(1, 0, 8'h40, 8'h00, 0, 0, 1, 8'h00, 8'h00);

        // Reset between a core read grant and its return edge drops rvalid.
        setInputs(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #3;
        checkOutput("pre_rst_core_gnt", core_gnt, 1);
        reset_n = 1'b0;
        #1 checkAllZero("rst_mid");
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK) #1;
        checkOutput("rst_mid_rvalid", core_rvalid, 0);
        @(negedge CLK) reset_n = 1'b1;
        modelReset();
        @(posedge CLK) #1;
        checkOutput("post_rst_rvalid", core_rvalid, 0);
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        applyStimulus(1, 0, 8'h50, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        checkOutput("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
